// File: rtl/instr_register_pkg.sv
// Shared instruction-register types plus the issue-scheduler state encoding.
package instr_register_pkg;

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   typedef logic signed [31:0] operand_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on contention the requester not granted last time wins.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] grant
);

   logic last_r;   // 1'b1: requester 1 held the most recent grant

   // grant selection
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_r ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // last-grant history, updated only when a grant is actually taken
   always_ff @(posedge clk) begin
      if (reset) begin
         last_r <= 1'b1;
      end else if (en && (grant != 2'b00)) begin
         last_r <= grant[1];
      end else begin
         last_r <= last_r;
      end
   end

endmodule

// File: rtl/instr_reg_sched.sv
// In-order queue over the instruction register: arbitrated writes in, FETCH/ISSUE
// scheduler out to the ALU.
module instr_reg_sched
   import instr_register_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  opcode_t            req_opcode [1:0],
   input  operand_t           req_op_a   [1:0],
   input  operand_t           req_op_b   [1:0],
   output logic               ir_load_en,
   output logic [PTR_W-1:0]   ir_write_pointer,
   output opcode_t            ir_opcode,
   output operand_t           ir_operand_a,
   output operand_t           ir_operand_b,
   output logic [PTR_W-1:0]   ir_read_pointer,
   input  instruction_t       ir_instr_word,
   output logic               iss_valid,
   input  logic               iss_ready,
   output instruction_t       iss_instr,
   output logic [PTR_W:0]     occupancy
);

   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nx_s;
   logic             ir_load_en_r;
   opcode_t          ir_opcode_r;
   operand_t         ir_operand_a_r;
   operand_t         ir_operand_b_r;
   sched_state_t     state_r;
   sched_state_t     state_nx_s;
   logic             iss_valid_r;
   logic             iss_valid_nx_s;
   instruction_t     iss_instr_r;
   instruction_t     iss_instr_nx_s;
   logic [1:0]       grant_s;
   logic             full_s;
   logic             accept_s;
   logic             win_s;
   logic             issue_s;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req_valid),
      .en    (accept_s),
      .grant (grant_s)
   );

   // The in-flight commit is counted early so a full queue is never over-accepted.
   assign full_s    = (count_r + CNT_W'(ir_load_en_r)) == CNT_W'(DEPTH);
   assign req_ready = grant_s & {2{~full_s & ~flush & ~reset}};
   assign accept_s  = |(req_valid & req_ready);
   assign win_s     = grant_s[1];
   assign issue_s   = iss_valid_r & iss_ready;

   // committed-slot count: +1 on commit, -1 on issue
   always_comb begin
      count_nx_s = count_r;
      if (flush) begin
         count_nx_s = CNT_W'(0);
      end else begin
         count_nx_s = count_r + CNT_W'(ir_load_en_r) - CNT_W'(issue_s);
      end
   end

   // issue FSM next state and registered-output next values
   always_comb begin
      state_nx_s     = state_r;
      iss_valid_nx_s = iss_valid_r;
      iss_instr_nx_s = iss_instr_r;
      if (flush) begin
         state_nx_s     = IDLE;
         iss_valid_nx_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (count_r != CNT_W'(0)) begin
                  state_nx_s = FETCH;
               end else begin
                  state_nx_s = IDLE;
               end
            end
            FETCH: begin
               iss_instr_nx_s = ir_instr_word;
               iss_valid_nx_s = 1'b1;
               state_nx_s     = ISSUE;
            end
            ISSUE: begin
               if (iss_ready) begin
                  iss_valid_nx_s = 1'b0;
                  state_nx_s     = (count_nx_s != CNT_W'(0)) ? FETCH : IDLE;
               end else begin
                  state_nx_s = ISSUE;
               end
            end
            default: begin
               state_nx_s     = IDLE;
               iss_valid_nx_s = 1'b0;
            end
         endcase
      end
   end

   // state, pointers, count and write-data registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= IDLE;
         iss_valid_r    <= 1'b0;
         iss_instr_r    <= '0;
         count_r        <= CNT_W'(0);
         wr_ptr_r       <= PTR_W'(0);
         rd_ptr_r       <= PTR_W'(0);
         ir_load_en_r   <= 1'b0;
         ir_opcode_r    <= ZERO;
         ir_operand_a_r <= 32'sd0;
         ir_operand_b_r <= 32'sd0;
      end else begin
         state_r      <= state_nx_s;
         iss_valid_r  <= iss_valid_nx_s;
         iss_instr_r  <= iss_instr_nx_s;
         count_r      <= count_nx_s;
         ir_load_en_r <= accept_s;
         if (accept_s) begin
            ir_opcode_r    <= req_opcode[win_s];
            ir_operand_a_r <= req_op_a[win_s];
            ir_operand_b_r <= req_op_b[win_s];
         end
         if (flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
         end else begin
            if (ir_load_en_r) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (issue_s)      rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   assign ir_load_en       = ir_load_en_r;
   assign ir_write_pointer = wr_ptr_r;
   assign ir_opcode        = ir_opcode_r;
   assign ir_operand_a     = ir_operand_a_r;
   assign ir_operand_b     = ir_operand_b_r;
   assign ir_read_pointer  = rd_ptr_r;
   assign iss_valid        = iss_valid_r;
   assign iss_instr        = iss_instr_r;
   assign occupancy        = count_r;

endmodule

// File: tb/tb_instr_reg_sched.sv
// Directed-plus-random bench: an instruction-register stand-in, a queue-level reference
// model checked every cycle, and directed scenario checks.
module tb_instr_reg_sched;
   import instr_register_pkg::*;

   localparam int DEPTH = 32;

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic         flush     = 1'b0;
   logic [1:0]   req_valid = 2'b00;
   logic [1:0]   req_ready;
   opcode_t      req_opcode [1:0];
   operand_t     req_op_a   [1:0];
   operand_t     req_op_b   [1:0];
   logic         ir_load_en;
   logic [4:0]   ir_write_pointer;
   opcode_t      ir_opcode;
   operand_t     ir_operand_a;
   operand_t     ir_operand_b;
   logic [4:0]   ir_read_pointer;
   instruction_t ir_instr_word;
   logic         iss_valid;
   logic         iss_ready = 1'b0;
   instruction_t iss_instr;
   logic [5:0]   occupancy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   instruction_t mem [DEPTH];
   instruction_t exp_q [$];
   instruction_t iss_log [$];
   int           occ = 0;
   logic [4:0]   wr_exp = 5'd0;
   logic [4:0]   rd_exp = 5'd0;
   logic         pend_v = 1'b0;
   instruction_t pend_item;
   int           last_g = 1;
   logic         hold_v = 1'b0;
   instruction_t hold_item;
   int           acc_cnt [2] = '{0, 0};
   bit           wrap_w = 1'b0;
   bit           wrap_r = 1'b0;

   instr_reg_sched dut (
      .clk              (clk),
      .reset            (reset),
      .flush            (flush),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_opcode       (req_opcode),
      .req_op_a         (req_op_a),
      .req_op_b         (req_op_b),
      .ir_load_en       (ir_load_en),
      .ir_write_pointer (ir_write_pointer),
      .ir_opcode        (ir_opcode),
      .ir_operand_a     (ir_operand_a),
      .ir_operand_b     (ir_operand_b),
      .ir_read_pointer  (ir_read_pointer),
      .ir_instr_word    (ir_instr_word),
      .iss_valid        (iss_valid),
      .iss_ready        (iss_ready),
      .iss_instr        (iss_instr),
      .occupancy        (occupancy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // instruction register stand-in: synchronous write, combinational read
   always @(posedge clk) begin
      if (ir_load_en) mem[ir_write_pointer] <= '{opc: ir_opcode, op_a: ir_operand_a, op_b: ir_operand_b};
   end
   assign ir_instr_word = mem[ir_read_pointer];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] grant_of(input logic [1:0] v, input int last);
      if (v == 2'b11) return (last == 1) ? 2'b01 : 2'b10;
      return v;
   endfunction

   function automatic instruction_t rnd_instr();
      instruction_t t;
      t.opc  = opcode_t'(4'($urandom_range(0, 7)));
      t.op_a = operand_t'($urandom);
      t.op_b = operand_t'($urandom);
      return t;
   endfunction

   task automatic set_req(input int r, input instruction_t t);
      req_opcode[r] = t.opc;
      req_op_a[r]   = t.op_a;
      req_op_b[r]   = t.op_b;
   endtask

   // reference model: FIFO of accepted instructions, one-cycle commit, committed count
   always @(negedge clk) begin
      logic [1:0]   exp_rdy;
      logic [1:0]   acc;
      logic         issue;
      instruction_t want;
      int           r;
      if (reset) begin
         occ = 0; wr_exp = 5'd0; rd_exp = 5'd0; pend_v = 1'b0; last_g = 1; hold_v = 1'b0;
         exp_q.delete();
      end else begin
         chk("load_en", 128'(ir_load_en), 128'(pend_v));
         if (pend_v) begin
            chk("wr_ptr", 128'(ir_write_pointer), 128'(wr_exp));
            chk("wr_data", 128'({ir_opcode, ir_operand_a, ir_operand_b}), 128'(pend_item));
         end
         chk("rd_ptr", 128'(ir_read_pointer), 128'(rd_exp));
         chk("occupancy", 128'(occupancy), 128'(occ));
         exp_rdy = (flush || (occ + int'(pend_v)) == DEPTH) ? 2'b00 : grant_of(req_valid, last_g);
         chk("req_ready", 128'(req_ready), 128'(exp_rdy));
         if (hold_v) begin
            chk("hold_valid", 128'(iss_valid), 128'(1'b1));
            chk("hold_instr", 128'(iss_instr), 128'(hold_item));
         end
         acc   = req_valid & exp_rdy;
         issue = iss_valid & iss_ready;
         if (issue) begin
            if (exp_q.size() != 0) want = exp_q.pop_front();
            else want = '1;
            chk("iss_order", 128'(iss_instr), 128'(want));
            iss_log.push_back(iss_instr);
            if (rd_exp == 5'd31) wrap_r = 1'b1;
         end
         if (flush) begin
            occ = 0; wr_exp = 5'd0; rd_exp = 5'd0; pend_v = 1'b0; hold_v = 1'b0;
            exp_q.delete();
         end else begin
            occ = occ + int'(pend_v) - int'(issue);
            if (pend_v && wr_exp == 5'd31) wrap_w = 1'b1;
            wr_exp = wr_exp + 5'(pend_v);
            rd_exp = rd_exp + 5'(issue);
            if (acc != 2'b00) begin
               r = acc[1] ? 1 : 0;
               pend_item = '{opc: req_opcode[r], op_a: req_op_a[r], op_b: req_op_b[r]};
               exp_q.push_back(pend_item);
               last_g = r;
               acc_cnt[r]++;
            end
            pend_v    = (acc != 2'b00);
            hold_v    = iss_valid & ~iss_ready;
            hold_item = iss_instr;
         end
      end
   end

   task automatic drain(input string tag);
      bit done;
      done      = 1'b0;
      req_valid = 2'b00;
      iss_ready = 1'b1;
      for (int n = 0; n < 400 && !done; n++) begin
         @(negedge clk);
         done = (occupancy == 6'd0) && !iss_valid && !ir_load_en;
      end
      chk(tag, 128'(done), 128'(1'b1));
      @(posedge clk); #1;
   endtask

   // accept n writes from requesters in mask, refreshing data after each acceptance
   task automatic write_n(input logic [1:0] mask, input int n, input string tag);
      int base;
      logic [1:0] a;
      base = acc_cnt[0] + acc_cnt[1];
      req_valid = mask;
      for (int k = 0; k < 400 && (acc_cnt[0] + acc_cnt[1] - base) < n; k++) begin
         @(negedge clk);
         a = req_valid & req_ready;
         @(posedge clk); #1;
         if (a[0]) set_req(0, rnd_instr());
         if (a[1]) set_req(1, rnd_instr());
      end
      chk(tag, 128'(acc_cnt[0] + acc_cnt[1] - base), 128'(n));
   endtask

   initial begin
      instruction_t t1 [3];
      instruction_t tb_b;
      int t0, lat, c0, c1;
      logic [1:0] a;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      for (int i = 0; i < 2; i++) set_req(i, rnd_instr());

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_load_en", 128'(ir_load_en), 128'(1'b0));
      chk("rst_iss_valid", 128'(iss_valid), 128'(1'b0));
      chk("rst_occupancy", 128'(occupancy), 128'(6'd0));
      chk("rst_rd_ptr", 128'(ir_read_pointer), 128'(5'd0));
      chk("rst_wr_ptr", 128'(ir_write_pointer), 128'(5'd0));
      chk("rst_iss_instr", 128'(iss_instr), 128'(68'd0));
      chk("rst_req_ready", 128'(req_ready), 128'(2'b00));

      // directed in-order writes from requester 0, latency of the first issue
      @(posedge clk); #1;
      t1[0] = '{opc: ADD,  op_a: 32'sd3,  op_b: 32'sd4};
      t1[1] = '{opc: SUB,  op_a: -32'sd5, op_b: 32'sd2};
      t1[2] = '{opc: MULT, op_a: 32'sd7,  op_b: 32'sd7};
      iss_log.delete();
      iss_ready = 1'b1;
      t0 = 0;
      for (int k = 0; k < 3; k++) begin
         set_req(0, t1[k]);
         req_valid = 2'b01;
         @(negedge clk);
         chk("t1_accept", 128'(req_ready), 128'(2'b01));
         if (k == 0) t0 = cyc;
         @(posedge clk); #1;
      end
      req_valid = 2'b00;
      lat = -1;
      for (int n = 0; n < 20 && lat < 0; n++) begin
         @(negedge clk);
         if (iss_valid) lat = cyc - t0;
      end
      chk("t1_latency", 128'(lat), 128'(4));
      @(posedge clk); #1;
      drain("t1_drain");
      chk("t1_count", 128'(iss_log.size()), 128'(3));
      for (int k = 0; k < 3 && k < iss_log.size(); k++) chk("t1_order", 128'(iss_log[k]), 128'(t1[k]));

      // contention: both requesters always valid
      c0 = acc_cnt[0]; c1 = acc_cnt[1];
      set_req(0, rnd_instr()); set_req(1, rnd_instr());
      write_n(2'b11, 20, "t2_writes");
      chk("t2_req0", 128'(acc_cnt[0] - c0), 128'(10));
      chk("t2_req1", 128'(acc_cnt[1] - c1), 128'(10));
      drain("t2_drain");

      // fill to DEPTH with the ALU stalled
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      iss_ready = 1'b0;
      write_n(2'b01, 32, "t3_writes");
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("t3_full_occ", 128'(occupancy), 128'(6'd32));
      chk("t3_full_ready", 128'(req_ready), 128'(2'b00));
      @(posedge clk); #1;
      iss_ready = 1'b1;
      @(negedge clk);
      chk("t3_issue", 128'(iss_valid), 128'(1'b1));
      @(posedge clk); #1;
      iss_ready = 1'b0;
      @(negedge clk);
      chk("t3_ready_rise", 128'(req_ready), 128'(2'b01));
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("t3_slot0_load", 128'(ir_load_en), 128'(1'b1));
      chk("t3_slot0_ptr", 128'(ir_write_pointer), 128'(5'd0));
      @(posedge clk); #1;
      drain("t3_drain");

      // random traffic across the pointer wrap
      wrap_w = 1'b0; wrap_r = 1'b0;
      c0 = acc_cnt[0] + acc_cnt[1];
      for (int k = 0; k < 2000 && (acc_cnt[0] + acc_cnt[1] - c0) < 40; k++) begin
         req_valid = 2'($urandom_range(0, 3));
         iss_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         a = req_valid & req_ready;
         @(posedge clk); #1;
         if (a[0]) set_req(0, rnd_instr());
         if (a[1]) set_req(1, rnd_instr());
      end
      chk("t4_writes", 128'(acc_cnt[0] + acc_cnt[1] - c0), 128'(40));
      drain("t4_drain");
      chk("t4_wr_wrap", 128'(wrap_w), 128'(1'b1));
      chk("t4_rd_wrap", 128'(wrap_r), 128'(1'b1));

      // commit and issue in the same cycle with one entry queued
      iss_ready = 1'b0;
      set_req(0, rnd_instr());
      write_n(2'b01, 1, "t5_first");
      req_valid = 2'b00;
      lat = -1;
      for (int n = 0; n < 20 && lat < 0; n++) begin
         @(negedge clk);
         if (iss_valid) lat = 0;
      end
      chk("t5_wait_issue", 128'(lat), 128'(0));
      @(posedge clk); #1;
      tb_b = '{opc: DIV, op_a: 32'sd100, op_b: -32'sd9};
      set_req(0, tb_b);
      req_valid = 2'b01;
      @(negedge clk);
      chk("t5_accept", 128'(req_ready), 128'(2'b01));
      @(posedge clk); #1;
      req_valid = 2'b00;
      iss_ready = 1'b1;
      @(negedge clk);
      chk("t5_commit", 128'(ir_load_en), 128'(1'b1));
      chk("t5_issue", 128'(iss_valid), 128'(1'b1));
      @(posedge clk); #1;
      iss_ready = 1'b0;
      @(negedge clk);
      chk("t5_occ", 128'(occupancy), 128'(6'd1));
      @(posedge clk); #1;
      drain("t5_drain");
      chk("t5_last", 128'(iss_log[$]), 128'(tb_b));

      // flush while an instruction is waiting in ISSUE
      iss_ready = 1'b0;
      write_n(2'b01, 5, "t6_writes");
      req_valid = 2'b00;
      lat = -1;
      for (int n = 0; n < 20 && lat < 0; n++) begin
         @(negedge clk);
         if (iss_valid && occupancy == 6'd5) lat = 0;
      end
      chk("t6_setup", 128'(lat), 128'(0));
      @(posedge clk); #1;
      flush = 1'b1;
      req_valid = 2'b01;
      @(negedge clk);
      chk("t6_no_accept", 128'(req_ready), 128'(2'b00));
      @(posedge clk); #1;
      flush = 1'b0;
      req_valid = 2'b00;
      @(negedge clk);
      chk("t6_iss_valid", 128'(iss_valid), 128'(1'b0));
      chk("t6_occ", 128'(occupancy), 128'(6'd0));
      chk("t6_rd_ptr", 128'(ir_read_pointer), 128'(5'd0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6_idle", 128'(iss_valid), 128'(1'b0));

      // reset while a write is being committed
      @(posedge clk); #1;
      set_req(0, '{opc: MOD, op_a: 32'sd11, op_b: 32'sd13});
      req_valid = 2'b01;
      @(negedge clk);
      chk("rm_accept", 128'(req_ready), 128'(2'b01));
      @(posedge clk); #1;
      req_valid = 2'b00;
      reset = 1'b1;
      @(negedge clk);
      chk("rm_inflight", 128'(ir_load_en), 128'(1'b1));
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rm_load_en", 128'(ir_load_en), 128'(1'b0));
      chk("rm_opcode", 128'(ir_opcode), 128'(4'd0));
      chk("rm_op_a", 128'(ir_operand_a), 128'(32'd0));
      chk("rm_op_b", 128'(ir_operand_b), 128'(32'd0));
      chk("rm_wr_ptr", 128'(ir_write_pointer), 128'(5'd0));
      chk("rm_occ", 128'(occupancy), 128'(6'd0));
      chk("rm_iss_valid", 128'(iss_valid), 128'(1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
